// File: rtl/gray_pkg.sv
// Shared constants and helpers for the RGB565 -> luma pipeline.
// Luma weights are BT.601 scaled by 256; ROUND gives round-to-nearest on the >>8.
package gray_pkg;
    localparam int K_R      = 77;
    localparam int K_G      = 150;
    localparam int K_B      = 29;
    localparam int ROUND    = 128;
    localparam int PIPE_LAT = 3;

    typedef struct packed {
        logic vsync;
        logic href;
        logic clken;
    } sync_t;

    // Replicate MSBs into the new LSBs so full-scale maps to 0xFF
    function automatic logic [7:0] expand5(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] v);
        return {v, v[5:4]};
    endfunction
endpackage

// File: rtl/rgb565_gray_pipe_sync_delay.sv
// N-stage shift register for W parallel control bits; output is the oldest stage.
module sync_delay #(
    parameter int W = 3,
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [N-1:0][W-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[N-2:0], din};
    end

    assign dout = sr[N-1];
endmodule

// File: rtl/rgb565_gray_pipe.sv
// RGB565 -> 8-bit luma with matched sync delay, x/y pixel tagging,
// frame line counting and a sticky line-length error.
module rgb565_gray_pipe
    import gray_pkg::*;
#(
    parameter int IMG_H_DISP = 800,
    parameter int IMG_V_DISP = 480,
    parameter int CNT_W      = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic [15:0]      per_img_rgb,
    input  logic             err_clr,
    output logic             post_frame_vsync,
    output logic             post_frame_href,
    output logic             post_frame_clken,
    output logic [7:0]       post_img_gray,
    output logic [CNT_W-1:0] post_pix_x,
    output logic [CNT_W-1:0] post_pix_y,
    output logic [CNT_W-1:0] frame_lines,
    output logic             line_len_err
);
    if (IMG_H_DISP >= 2**CNT_W || IMG_V_DISP >= 2**CNT_W) begin : g_bad_cfg
        $error("CNT_W too narrow for the configured image geometry");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [7:0]  r8, g8, b8;
    logic [15:0] p_r, p_g, p_b;
    logic [7:0]  s2_hi;

    assign r8 = expand5(per_img_rgb[15:11]);
    assign g8 = expand6(per_img_rgb[10:5]);
    assign b8 = expand5(per_img_rgb[4:0]);

    // Free-running MAC; max sum is 65408 so 16 bits never overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r           <= '0;
            p_g           <= '0;
            p_b           <= '0;
            s2_hi         <= '0;
            post_img_gray <= '0;
        end else begin
            p_r           <= 16'(r8) * 16'(K_R);
            p_g           <= 16'(g8) * 16'(K_G);
            p_b           <= 16'(b8) * 16'(K_B);
            s2_hi         <= 8'((p_r + p_g + p_b + 16'(ROUND)) >> 8);
            post_img_gray <= s2_hi;
        end
    end

    sync_t sync_in, sync_out;

    assign sync_in = '{vsync: per_frame_vsync,
                       href:  per_frame_vsync & per_frame_href,
                       clken: per_frame_clken};

    sync_delay #(.W(3), .N(PIPE_LAT)) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sync_in),
        .dout  (sync_out)
    );

    assign post_frame_vsync = sync_out.vsync;
    assign post_frame_href  = sync_out.href;
    assign post_frame_clken = sync_out.clken;

    logic                href_q, vsync_q;
    logic [PIPE_LAT-1:0] vld_pipe;
    logic                primed, armed;
    logic                href_rise, href_fall, vsync_fall, pix_vld;

    assign href_rise  =  post_frame_href  & ~href_q;
    assign href_fall  = ~post_frame_href  &  href_q;
    assign vsync_fall = ~post_frame_vsync &  vsync_q;
    assign pix_vld    =  post_frame_clken &  post_frame_href;

    // vld_pipe marks when the delay line holds only post-reset samples;
    // a rise seen before then is a line already in progress and must not arm
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            vld_pipe     <= '0;
            primed       <= 1'b0;
            armed        <= 1'b0;
            post_pix_x   <= '0;
            post_pix_y   <= '0;
            frame_lines  <= '0;
            line_len_err <= 1'b0;
        end else begin
            href_q   <= post_frame_href;
            vsync_q  <= post_frame_vsync;
            vld_pipe <= {vld_pipe[PIPE_LAT-2:0], 1'b1};

            if (vld_pipe[PIPE_LAT-1] && !post_frame_href) primed <= 1'b1;
            if (primed && href_rise)                      armed  <= 1'b1;

            if (!post_frame_href)                   post_pix_x <= '0;
            else if (pix_vld && post_pix_x != CNT_MAX) post_pix_x <= post_pix_x + 1'b1;

            if (!post_frame_vsync)                     post_pix_y <= '0;
            else if (href_fall && post_pix_y != CNT_MAX) post_pix_y <= post_pix_y + 1'b1;

            if (vsync_fall) frame_lines <= post_pix_y;

            // Clear wins over a same-cycle detection
            if (err_clr)
                line_len_err <= 1'b0;
            else if (href_fall && armed && post_pix_x != CNT_W'(IMG_H_DISP))
                line_len_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rgb565_gray_pipe.sv
// Bench for rgb565_gray_pipe: vector table for luma/latency, scoreboard for
// every output pixel (gray, x, y), hand sequences for error/reset/vsync corners.
module tb_rgb565_gray_pipe;
    localparam int H     = 800;
    localparam int CNT_W = 11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             vsync = 1'b0, href = 1'b0, clken = 1'b0, err_clr = 1'b0;
    logic [15:0]      rgb = '0;
    logic             post_vsync, post_href, post_clken, line_len_err;
    logic [7:0]       post_gray;
    logic [CNT_W-1:0] pix_x, pix_y, frame_lines;

    always #5 clk = ~clk;

    rgb565_gray_pipe #(.IMG_H_DISP(H), .IMG_V_DISP(480), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (vsync),
        .per_frame_href   (href),
        .per_frame_clken  (clken),
        .per_img_rgb      (rgb),
        .err_clr          (err_clr),
        .post_frame_vsync (post_vsync),
        .post_frame_href  (post_href),
        .post_frame_clken (post_clken),
        .post_img_gray    (post_gray),
        .post_pix_x       (pix_x),
        .post_pix_y       (pix_y),
        .frame_lines      (frame_lines),
        .line_len_err     (line_len_err)
    );

    typedef struct { logic [7:0] gray; int x; int y; } exp_t;
    typedef struct { logic [15:0] rgb; logic [7:0] gray; } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vt[5];
    int   errors = 0, checks = 0;
    int   mx = 0, my = 0;
    bit   href_seen = 1'b0;

    function automatic logic [7:0] gray_of(input logic [15:0] p);
        int r, g, b;
        r = {p[15:11], p[15:13]};
        g = {p[10:5],  p[10:9]};
        b = {p[4:0],   p[4:2]};
        return 8'((r * 77 + g * 150 + b * 29 + 128) >> 8);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [15:0] p);
        rgb   = p;
        clken = 1'b1;
        if (vsync && href && rst_n) begin
            sbq.push_back('{gray_of(p), mx, my});
            mx++;
        end
        step();
        clken = 1'b0;
        rgb   = 16'($urandom);
        step();
    endtask

    // clr_at_fall lines err_clr up with the cycle the DUT sees the delayed href fall
    task automatic send_line(input int n, input bit clr_at_fall);
        href = 1'b1;
        mx   = 0;
        step();
        step();
        for (int i = 0; i < n; i++) pix(16'($urandom));
        href = 1'b0;
        if (vsync) my++;
        if (clr_at_fall) begin
            repeat (3) step();
            err_clr = 1'b1;
            step();
            err_clr = 1'b0;
        end
        repeat (6) step();
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        my    = 0;
        repeat (4) step();
    endtask

    task automatic frame_end();
        vsync = 1'b0;
        repeat (6) step();
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vsync"}, post_vsync, 0);
        check({tag, "_href"},  post_href, 0);
        check({tag, "_clken"}, post_clken, 0);
        check({tag, "_gray"},  post_gray, 0);
        check({tag, "_x"},     pix_x, 0);
        check({tag, "_y"},     pix_y, 0);
        check({tag, "_lines"}, frame_lines, 0);
        check({tag, "_err"},   line_len_err, 0);
    endtask

    always @(negedge clk) begin
        if (post_href) href_seen = 1'b1;
        if (rst_n && post_clken && post_href) begin
            if (sbq.size() == 0) begin
                check("unexpected_pixel", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                check("sb_gray", post_gray, mon_e.gray);
                check("sb_x", pix_x, mon_e.x);
                check("sb_y", pix_y, mon_e.y);
            end
        end
    end

    initial begin
        // 150*255+128 = 38378 -> 0x95 after >>8
        vt[0] = '{16'hFFFF, 8'hFF};
        vt[1] = '{16'h0000, 8'h00};
        vt[2] = '{16'hF800, 8'h4D};
        vt[3] = '{16'h07E0, 8'h95};
        vt[4] = '{16'h001F, 8'h1D};

        // Reset state with busy inputs
        vsync = 1'b1; href = 1'b1; clken = 1'b1; rgb = 16'hFFFF;
        repeat (3) step();
        check_all_zero("reset");
        vsync = 1'b0; href = 1'b0; clken = 1'b0;
        rst_n = 1'b1;
        repeat (5) step();

        // Luma vectors and 3-clk latency
        frame_start();
        href = 1'b1;
        mx   = 0;
        repeat (4) step();
        for (int i = 0; i < 5; i++) begin
            rgb   = vt[i].rgb;
            clken = 1'b1;
            sbq.push_back('{vt[i].gray, mx, my});
            mx++;
            step();
            clken = 1'b0;
            step();
            check("lat_early_clken", post_clken, 0);
            step();
            check("lat_clken", post_clken, 1);
            check("vec_gray", post_gray, vt[i].gray);
        end
        href = 1'b0;
        my++;
        repeat (6) step();
        check("short_line_err", line_len_err, 1);
        pulse_clr();
        check("clr_err", line_len_err, 0);
        frame_end();
        check("frame_lines_1", frame_lines, 1);

        // Good 4-line frame
        frame_start();
        for (int l = 0; l < 4; l++) send_line(H, 1'b0);
        frame_end();
        check("frame_lines_4", frame_lines, 4);
        check("good_frame_err", line_len_err, 0);

        // 799-pixel line, error sticky across frames
        frame_start();
        send_line(H, 1'b0);
        check("pre_bad_err", line_len_err, 0);
        send_line(H - 1, 1'b0);
        check("bad_line_err", line_len_err, 1);
        frame_end();
        check("frame_lines_2", frame_lines, 2);
        frame_start();
        send_line(H, 1'b0);
        frame_end();
        check("sticky_err", line_len_err, 1);
        pulse_clr();
        check("clr_after_sticky", line_len_err, 0);

        // err_clr coinciding with a bad-line fall
        frame_start();
        send_line(H - 1, 1'b1);
        check("clr_wins_err", line_len_err, 0);
        send_line(H, 1'b0);
        check("after_clr_wins_err", line_len_err, 0);
        frame_end();

        // Reset mid-line, release mid-line
        frame_start();
        href = 1'b1;
        mx   = 0;
        step();
        step();
        for (int i = 0; i < 300; i++) pix(16'($urandom));
        rst_n = 1'b0;
        sbq.delete();
        step();
        step();
        check_all_zero("midreset");
        mx = 0;
        my = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) pix(16'($urandom));
        href = 1'b0;
        my++;
        repeat (6) step();
        check("partial_unchecked", line_len_err, 0);
        send_line(H - 1, 1'b0);
        check("post_reset_checked", line_len_err, 1);
        frame_end();
        check("frame_lines_reset", frame_lines, 2);
        pulse_clr();
        check("clr_after_reset", line_len_err, 0);

        // href with vsync low is ignored
        href_seen = 1'b0;
        for (int l = 0; l < 3; l++) send_line(20, 1'b0);
        check("novsync_href", href_seen, 0);
        check("novsync_y", pix_y, 0);
        check("novsync_x", pix_x, 0);
        check("novsync_err", line_len_err, 0);

        repeat (8) step();
        check("sb_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
